// File: rtl/VX_gpu_pkg.sv
// Shared GPU cluster types: global-barrier request/response records and sizing constants.
package VX_gpu_pkg;

  localparam int GBAR_NUM_CORES    = 4;
  localparam int GBAR_NUM_BARRIERS = 8;
  localparam int GBAR_ID_BITS      = (GBAR_NUM_BARRIERS > 1) ? $clog2(GBAR_NUM_BARRIERS) : 1;
  localparam int GBAR_CORE_BITS    = (GBAR_NUM_CORES > 1) ? $clog2(GBAR_NUM_CORES) : 1;

  typedef struct packed {
    logic [GBAR_ID_BITS-1:0]   id;
    logic [GBAR_CORE_BITS-1:0] size_m1;
    logic [GBAR_CORE_BITS-1:0] core_id;
  } gbar_req_t;

  typedef struct packed {
    logic [GBAR_ID_BITS-1:0] id;
  } gbar_rsp_t;

  typedef enum logic {
    GBAR_IDLE    = 1'b0,
    GBAR_COLLECT = 1'b1
  } gbar_state_e;

endpackage

// File: rtl/VX_popcount.sv
// Combinational population count of an N-bit vector into a W-bit result.
module VX_popcount #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] data,
  output logic [W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + W'(data[i]);
    end
  end

endmodule

// File: rtl/vx_gbar_sched.sv
// Cluster global-barrier scheduler: per-ID arrival masks, one-cycle release pulse when the
// participating core count is reached. One request per cycle, no backpressure on releases.
module vx_gbar_sched
  import VX_gpu_pkg::*;
#(
  parameter int NUM_CORES    = GBAR_NUM_CORES,
  parameter int NUM_BARRIERS = GBAR_NUM_BARRIERS,
  parameter int PERF_W       = 32,
  localparam int CORE_ID_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int BAR_ID_W    = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BAR_ID_W-1:0]  req_id,
  input  logic [CORE_ID_W-1:0] req_size_m1,
  input  logic [CORE_ID_W-1:0] req_core_id,
  output logic                 rsp_valid,
  output logic [BAR_ID_W-1:0]  rsp_id,
  output logic                 busy,
  output logic                 err_dup,
  output logic                 err_size,
  output logic [PERF_W-1:0]    perf_releases
);

  localparam int CNT_W = CORE_ID_W + 1;

  gbar_state_e          state_q [NUM_BARRIERS];
  gbar_state_e          state_d [NUM_BARRIERS];
  logic [CORE_ID_W-1:0] size_q  [NUM_BARRIERS];
  logic [CORE_ID_W-1:0] size_d  [NUM_BARRIERS];
  logic [NUM_CORES-1:0] mask_q  [NUM_BARRIERS];
  logic [NUM_CORES-1:0] mask_d  [NUM_BARRIERS];

  logic                 ready_q;
  logic                 rsp_valid_q;
  logic [BAR_ID_W-1:0]  rsp_id_q;
  logic                 err_dup_q, err_size_q;
  logic [PERF_W-1:0]    perf_q;

  logic                 accept, id_ok, core_ok, do_update, collect;
  logic                 release_c, dup_c, size_mis_c, busy_c;
  logic [BAR_ID_W-1:0]  sel;
  logic [NUM_CORES-1:0] onehot, cur_mask, new_mask;
  logic [CORE_ID_W-1:0] eff_size;
  logic [CNT_W-1:0]     cnt, target;

  VX_popcount #(.N(NUM_CORES), .W(CNT_W)) u_popcount (
    .data (new_mask),
    .cnt  (cnt)
  );

  always_comb begin
    accept     = req_valid && ready_q;
    id_ok      = int'(req_id) < NUM_BARRIERS;
    core_ok    = int'(req_core_id) < NUM_CORES;
    do_update  = accept && id_ok && core_ok;
    // Out-of-range IDs must not index the table; the update is suppressed anyway.
    sel        = id_ok ? req_id : '0;
    collect    = (state_q[sel] == GBAR_COLLECT);
    cur_mask   = collect ? mask_q[sel] : '0;
    onehot     = NUM_CORES'(1) << req_core_id;
    new_mask   = cur_mask | onehot;
    eff_size   = collect ? size_q[sel] : req_size_m1;
    target     = {1'b0, eff_size} + CNT_W'(1);
    release_c  = do_update && (cnt == target);
    dup_c      = do_update && collect && ((cur_mask & onehot) != '0);
    size_mis_c = do_update && collect && (req_size_m1 != size_q[sel]);

    state_d = state_q;
    size_d  = size_q;
    mask_d  = mask_q;
    if (do_update) begin
      if (release_c) begin
        state_d[sel] = GBAR_IDLE;
        mask_d[sel]  = '0;
      end else begin
        if (!collect) size_d[sel] = req_size_m1;
        state_d[sel] = GBAR_COLLECT;
        mask_d[sel]  = new_mask;
      end
    end

    busy_c = 1'b0;
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      busy_c = busy_c | (state_q[i] == GBAR_COLLECT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        state_q[i] <= GBAR_IDLE;
        size_q[i]  <= '0;
        mask_q[i]  <= '0;
      end
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      err_dup_q   <= 1'b0;
      err_size_q  <= 1'b0;
      perf_q      <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      mask_q      <= mask_d;
      ready_q     <= 1'b1;
      rsp_valid_q <= release_c;
      if (release_c) rsp_id_q <= req_id;
      // A bad core ID is reported as a duplicate-class error and otherwise ignored.
      if (dup_c || (accept && !core_ok)) err_dup_q <= 1'b1;
      if (size_mis_c) err_size_q <= 1'b1;
      perf_q      <= perf_q + PERF_W'(release_c);
    end
  end

  assign req_ready     = ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign busy          = busy_c;
  assign err_dup       = err_dup_q;
  assign err_size      = err_size_q;
  assign perf_releases = perf_q;

endmodule

// File: tb/tb_vx_gbar_sched.sv
// Directed vector bench for vx_gbar_sched (4 cores, 8 barriers); each row is one clock.
module tb_vx_gbar_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_id;
  logic [1:0]  req_size_m1;
  logic [1:0]  req_core_id;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic        busy;
  logic        err_dup;
  logic        err_size;
  logic [31:0] perf_releases;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_gbar_sched #(.NUM_CORES(4), .NUM_BARRIERS(8), .PERF_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_id        (req_id),
    .req_size_m1   (req_size_m1),
    .req_core_id   (req_core_id),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .busy          (busy),
    .err_dup       (err_dup),
    .err_size      (err_size),
    .perf_releases (perf_releases)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [2:0] id;
    logic [1:0] sz;
    logic [1:0] core;
    logic       e_rdy;
    logic       e_vld;
    logic [2:0] e_id;
    logic       e_busy;
    logic       e_dup;
    logic       e_size;
    int         e_perf;
  } vec_t;

  vec_t vq[$];

  task automatic row(input logic rst, input logic vld, input logic [2:0] id, input logic [1:0] sz,
                     input logic [1:0] core, input logic e_rdy, input logic e_vld,
                     input logic [2:0] e_id, input logic e_busy, input logic e_dup,
                     input logic e_size, input int e_perf);
    vec_t v;
    v.rst = rst; v.vld = vld; v.id = id; v.sz = sz; v.core = core;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_id = e_id; v.e_busy = e_busy;
    v.e_dup = e_dup; v.e_size = e_size; v.e_perf = e_perf;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample the registered outputs just after the edge.
  task automatic step(input logic rst, input logic vld, input logic [2:0] id,
                      input logic [1:0] sz, input logic [1:0] core);
    reset = rst; req_valid = vld; req_id = id; req_size_m1 = sz; req_core_id = core;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_id = '0; req_size_m1 = '0; req_core_id = '0;
    #1;

    //   rst vld id sz core | rdy vld id busy dup size perf
    row(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    // Four-core barrier on id 2
    row(0, 1, 2, 3, 0,  1, 0, 0, 1, 0, 0, 0);
    row(0, 1, 2, 3, 1,  1, 0, 0, 1, 0, 0, 0);
    row(0, 1, 2, 3, 2,  1, 0, 0, 1, 0, 0, 0);
    row(0, 1, 2, 3, 3,  1, 1, 2, 0, 0, 0, 1);
    row(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1);
    // Single-core barrier releases immediately
    row(0, 1, 5, 0, 1,  1, 1, 5, 0, 0, 0, 2);
    row(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 2);
    // Duplicate arrival on id 1
    row(0, 1, 1, 1, 0,  1, 0, 0, 1, 0, 0, 2);
    row(0, 1, 1, 1, 0,  1, 0, 0, 1, 1, 0, 2);
    row(0, 1, 1, 1, 1,  1, 1, 1, 0, 1, 0, 3);
    // Size mismatch: latched size 1 governs
    row(0, 1, 3, 1, 0,  1, 0, 0, 1, 1, 0, 3);
    row(0, 1, 3, 3, 2,  1, 1, 3, 0, 1, 1, 4);
    // Interleaved ids 0 and 7, back-to-back releases
    row(0, 1, 0, 1, 0,  1, 0, 0, 1, 1, 1, 4);
    row(0, 1, 7, 1, 0,  1, 0, 0, 1, 1, 1, 4);
    row(0, 1, 0, 1, 1,  1, 1, 0, 1, 1, 1, 5);
    row(0, 1, 7, 1, 1,  1, 1, 7, 0, 1, 1, 6);
    // Same core re-arrives on id 7 right after release: fresh epoch
    row(0, 1, 7, 1, 1,  1, 0, 0, 1, 1, 1, 6);
    row(0, 1, 7, 1, 0,  1, 1, 7, 0, 1, 1, 7);
    row(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1, 7);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].vld, vq[i].id, vq[i].sz, vq[i].core);
      chk("req_ready", i, 32'(req_ready), 32'(vq[i].e_rdy));
      chk("rsp_valid", i, 32'(rsp_valid), 32'(vq[i].e_vld));
      if (vq[i].e_vld) chk("rsp_id", i, 32'(rsp_id), 32'(vq[i].e_id));
      chk("busy", i, 32'(busy), 32'(vq[i].e_busy));
      chk("err_dup", i, 32'(err_dup), 32'(vq[i].e_dup));
      chk("err_size", i, 32'(err_size), 32'(vq[i].e_size));
      chk("perf_releases", i, perf_releases, 32'(vq[i].e_perf));
    end

    // Reset while id 4 holds three of four arrivals
    step(0, 1, 4, 3, 0);
    step(0, 1, 4, 3, 1);
    step(0, 1, 4, 3, 2);
    chk("pre_reset_busy", 100, 32'(busy), 32'd1);
    step(1, 0, 0, 0, 0);
    chk("rst_busy", 101, 32'(busy), 32'd0);
    chk("rst_rsp_valid", 101, 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 101, 32'(rsp_id), 32'd0);
    chk("rst_err_dup", 101, 32'(err_dup), 32'd0);
    chk("rst_err_size", 101, 32'(err_size), 32'd0);
    chk("rst_perf", 101, perf_releases, 32'd0);
    chk("rst_ready", 101, 32'(req_ready), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("post_rst_ready", 102, 32'(req_ready), 32'd1);
    chk("post_rst_rsp_valid", 102, 32'(rsp_valid), 32'd0);
    // Fourth core alone now opens a new epoch instead of releasing
    step(0, 1, 4, 3, 3);
    chk("new_epoch_rsp_valid", 103, 32'(rsp_valid), 32'd0);
    chk("new_epoch_busy", 103, 32'(busy), 32'd1);
    chk("new_epoch_perf", 103, perf_releases, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("idle_rsp_valid", 104, 32'(rsp_valid), 32'd0);
    chk("idle_busy", 104, 32'(busy), 32'd1);
    chk("idle_err_dup", 104, 32'(err_dup), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
